// File: rtl/ahbl_dma_master.sv
// Single-channel AHB-lite DMA master: copies count DW-wide words from src_addr to dst_addr.
// Latency: 4 cycles per word with zero-wait slaves (done 4N+1 cycles after start; 1 cycle for count=0).
// Backpressure: HREADY=0 holds the current address or data phase with all bus outputs frozen.
//
// Ports:
//   HCLK, HRESETn               clock, asynchronous active-low reset
//   start, src_addr, dst_addr,  copy request and its parameters, sampled only in IDLE
//   count
//   busy, done, remaining       status: copy in progress, one-cycle completion pulse, words left
//   HADDR/HTRANS/HWRITE/HSIZE/  AHB-lite master outputs (registered; HSIZE is constant)
//   HWDATA
//   HREADY, HRDATA              AHB-lite slave response
//   abort, aborted              stop request / abort status at done (AHBL_DMA_ABORT_EN only)
//
// Optional feature macro: AHBL_DMA_ABORT_EN adds the abort input and aborted output.
module ahbl_dma_master #(
    parameter int AW = 32,
    parameter int DW = 64            // 32 or 64 only
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [15:0]   count,
`ifdef AHBL_DMA_ABORT_EN
    input  logic          abort,
    output logic          aborted,
`endif
    output logic          busy,
    output logic          done,
    output logic [15:0]   remaining,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [DW-1:0] HWDATA,
    input  logic          HREADY,
    input  logic [DW-1:0] HRDATA
);

    localparam logic [1:0]    TR_IDLE   = 2'b00;
    localparam logic [1:0]    TR_NONSEQ = 2'b10;
    localparam logic [AW-1:0] STEP      = AW'(DW / 8);
    localparam logic [2:0]    SIZE      = (DW == 64) ? 3'b011 : 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_D,
        S_WR_A,
        S_WR_D,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [AW-1:0] src_ptr, dst_ptr, src_nxt, dst_nxt;
    logic [DW-1:0] data_buf, buf_nxt;
    logic [15:0]   rem_nxt;
    logic          busy_nxt, done_nxt, hwrite_nxt;
    logic [1:0]    htrans_nxt;
    logic [AW-1:0] haddr_nxt;
    logic [DW-1:0] hwdata_nxt;

`ifdef AHBL_DMA_ABORT_EN
    logic abort_req, abort_req_nxt, abort_hit, aborted_nxt;
`endif

    assign HSIZE = SIZE;

    // Next-state and next-output logic. Every output register is loaded from
    // a value derived from state_nxt, so the bus signals are already correct
    // in the first cycle of each state.
    always_comb begin
        state_nxt = state;
        src_nxt   = src_ptr;
        dst_nxt   = dst_ptr;
        rem_nxt   = remaining;
        buf_nxt   = data_buf;
`ifdef AHBL_DMA_ABORT_EN
        // A stop request seen in the same cycle as the final beat still counts.
        abort_hit     = abort_req | abort;
        aborted_nxt   = 1'b0;
        abort_req_nxt = abort_req;
        if (state == S_DONE) begin
            abort_req_nxt = 1'b0;
        end else if (abort && (state inside {S_RD_A, S_RD_D, S_WR_A, S_WR_D})) begin
            abort_req_nxt = 1'b1;
        end
`endif

        case (state)
            S_IDLE: begin
                if (start) begin
                    src_nxt   = src_addr;
                    dst_nxt   = dst_addr;
                    rem_nxt   = count;
                    state_nxt = (count == 16'd0) ? S_DONE : S_RD_A;
                end
            end
            S_RD_A: begin
                if (HREADY) state_nxt = S_RD_D;
            end
            S_RD_D: begin
                if (HREADY) begin
                    buf_nxt   = HRDATA;
                    state_nxt = S_WR_A;
                end
            end
            S_WR_A: begin
                if (HREADY) state_nxt = S_WR_D;
            end
            S_WR_D: begin
                if (HREADY) begin
                    // Pointers wrap modulo 2^AW by plain truncation.
                    src_nxt = src_ptr + STEP;
                    dst_nxt = dst_ptr + STEP;
                    rem_nxt = remaining - 16'd1;
`ifdef AHBL_DMA_ABORT_EN
                    aborted_nxt = abort_hit;
                    state_nxt   = (rem_nxt == 16'd0 || abort_hit) ? S_DONE : S_RD_A;
`else
                    state_nxt   = (rem_nxt == 16'd0) ? S_DONE : S_RD_A;
`endif
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt   = state_nxt inside {S_RD_A, S_RD_D, S_WR_A, S_WR_D};
        done_nxt   = (state_nxt == S_DONE);
        htrans_nxt = (state_nxt inside {S_RD_A, S_WR_A}) ? TR_NONSEQ : TR_IDLE;
        hwrite_nxt = (state_nxt == S_WR_A);

        // HADDR only moves when an address phase begins; otherwise it holds.
        if (state_nxt == S_RD_A) begin
            haddr_nxt = src_nxt;
        end else if (state_nxt == S_WR_A) begin
            haddr_nxt = dst_nxt;
        end else begin
            haddr_nxt = HADDR;
        end

        // HWDATA is loaded once on entry to the write data phase and held
        // through any wait states.
        if (state == S_WR_A && state_nxt == S_WR_D) begin
            hwdata_nxt = data_buf;
        end else begin
            hwdata_nxt = HWDATA;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            data_buf  <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            HADDR     <= '0;
            HTRANS    <= TR_IDLE;
            HWRITE    <= 1'b0;
            HWDATA    <= '0;
        end else begin
            src_ptr   <= src_nxt;
            dst_ptr   <= dst_nxt;
            data_buf  <= buf_nxt;
            remaining <= rem_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            HADDR     <= haddr_nxt;
            HTRANS    <= htrans_nxt;
            HWRITE    <= hwrite_nxt;
            HWDATA    <= hwdata_nxt;
        end
    end

`ifdef AHBL_DMA_ABORT_EN
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            abort_req <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            abort_req <= abort_req_nxt;
            aborted   <= aborted_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_ahbl_dma_master.sv
module tb_ahbl_dma_master;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam logic [63:0] DBASE = 64'hA5A5_0000_0000_0000;
`ifdef AHBL_DMA_ABORT_EN
    localparam int NV = 7;
`else
    localparam int NV = 6;
`endif

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [15:0]   count = '0;
    logic          busy, done;
    logic [15:0]   remaining;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [DW-1:0] HWDATA;
    logic          HREADY;
    logic [DW-1:0] HRDATA;
`ifdef AHBL_DMA_ABORT_EN
    logic          abort = 1'b0;
    logic          aborted;
`endif

    ahbl_dma_master #(.AW(AW), .DW(DW)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .count     (count),
`ifdef AHBL_DMA_ABORT_EN
        .abort     (abort),
        .aborted   (aborted),
`endif
        .busy      (busy),
        .done      (done),
        .remaining (remaining),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA)
    );

    always #5 HCLK = ~HCLK;

    // ---------------- slave model ----------------
    logic [63:0] mem [16];
    logic        dp_vld, dp_wr;
    logic [31:0] dp_addr;
    int          waits = 0;
    int          wcnt;
    int          wr_tot = 0, rd_tot = 0;
    logic [31:0] wr_addr_log [256];
    logic [63:0] wr_data_log [256];
    logic [31:0] rd_addr_log [256];

    // Every phase of a busy copy sees 'waits' stalled cycles before HREADY.
    assign HREADY = !busy || (wcnt == waits);
    assign HRDATA = (dp_vld && !dp_wr) ? mem[dp_addr[6:3]] : '0;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) wcnt <= 0;
        else          wcnt <= (!busy || HREADY) ? 0 : wcnt + 1;
    end

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_vld  <= 1'b0;
            dp_wr   <= 1'b0;
            dp_addr <= '0;
        end else if (HREADY) begin
            if (dp_vld && dp_wr && wr_tot < 256) begin
                wr_addr_log[wr_tot] <= dp_addr;
                wr_data_log[wr_tot] <= HWDATA;
                wr_tot <= wr_tot + 1;
            end
            if (HTRANS == 2'b10 && !HWRITE && rd_tot < 256) begin
                rd_addr_log[rd_tot] <= HADDR;
                rd_tot <= rd_tot + 1;
            end
            dp_vld  <= (HTRANS == 2'b10);
            dp_wr   <= HWRITE;
            dp_addr <= HADDR;
        end
    end

    // ---------------- stall stability monitor ----------------
    logic [31:0] p_haddr;
    logic [1:0]  p_htrans;
    logic        p_hwrite;
    logic [63:0] p_hwdata;
    logic        p_stall = 1'b0;
    int          stall_viol = 0, stall_seen = 0;

    always @(negedge HCLK) begin
        if (p_stall && HRESETn) begin
            stall_seen = stall_seen + 1;
            if (HADDR !== p_haddr || HTRANS !== p_htrans ||
                HWRITE !== p_hwrite || HWDATA !== p_hwdata)
                stall_viol = stall_viol + 1;
        end
        p_stall  = HRESETn && busy && !HREADY;
        p_haddr  = HADDR;
        p_htrans = HTRANS;
        p_hwrite = HWRITE;
        p_hwdata = HWDATA;
    end

    // ---------------- checking ----------------
    int n_tests = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] src, dst;
        logic [15:0] cnt;
        int          waits;
        logic [31:0] smask, amask;   // bit c: drive start(count=5)/abort in cycle c
        int          exp_done, nrd, nwr;
        logic [31:0] rd0, rdl, wa0, wal;
        logic [63:0] wd0, wdl;
        logic [15:0] rem;
        logic        ab;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] src, input logic [31:0] dst,
                                input logic [15:0] cnt, input int w,
                                input logic [31:0] smask, input logic [31:0] amask,
                                input int exp_done, input int nrd, input int nwr,
                                input logic [31:0] rd0, input logic [31:0] rdl,
                                input logic [31:0] wa0, input logic [63:0] wd0,
                                input logic [31:0] wal, input logic [63:0] wdl,
                                input logic [15:0] rem, input logic ab);
        vec_t v;
        v.src = src; v.dst = dst; v.cnt = cnt; v.waits = w;
        v.smask = smask; v.amask = amask;
        v.exp_done = exp_done; v.nrd = nrd; v.nwr = nwr;
        v.rd0 = rd0; v.rdl = rdl; v.wa0 = wa0; v.wd0 = wd0; v.wal = wal; v.wdl = wdl;
        v.rem = rem; v.ab = ab;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int done_c, busy_c, rd_base, wr_base;
        waits = v.waits;
        @(posedge HCLK); #1;
        src_addr = v.src; dst_addr = v.dst; count = v.cnt; start = 1'b1;
        rd_base = rd_tot; wr_base = wr_tot;
        @(posedge HCLK); #1;
        start = 1'b0;
        done_c = -1; busy_c = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge HCLK);
            start = 1'b0;
            if (c < 32) begin
                if (v.smask[c]) begin
                    start = 1'b1;
                    count = 16'd5;
                end
`ifdef AHBL_DMA_ABORT_EN
                abort = v.amask[c];
`endif
            end
            if (busy) busy_c++;
            if (done) begin
                done_c = c;
                break;
            end
        end
        start = 1'b0;
`ifdef AHBL_DMA_ABORT_EN
        abort = 1'b0;
        chk({tag, "_aborted"}, 64'(aborted), 64'(v.ab));
`endif
        chk({tag, "_done_cycle"}, 64'(done_c), 64'(v.exp_done));
        chk({tag, "_busy_cycles"}, 64'(busy_c), 64'(v.exp_done - 1));
        chk({tag, "_remaining"}, 64'(remaining), 64'(v.rem));
        @(negedge HCLK);
        chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        repeat (3) @(negedge HCLK);
        chk({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
        chk({tag, "_n_reads"}, 64'(rd_tot - rd_base), 64'(v.nrd));
        chk({tag, "_n_writes"}, 64'(wr_tot - wr_base), 64'(v.nwr));
        if (v.nrd > 0 && rd_tot > rd_base) begin
            chk({tag, "_rd_first"}, 64'(rd_addr_log[rd_base]), 64'(v.rd0));
            chk({tag, "_rd_last"}, 64'(rd_addr_log[rd_tot-1]), 64'(v.rdl));
        end
        if (v.nwr > 0 && wr_tot > wr_base) begin
            chk({tag, "_wa_first"}, 64'(wr_addr_log[wr_base]), 64'(v.wa0));
            chk({tag, "_wd_first"}, wr_data_log[wr_base], v.wd0);
            chk({tag, "_wa_last"}, 64'(wr_addr_log[wr_tot-1]), 64'(v.wal));
            chk({tag, "_wd_last"}, wr_data_log[wr_tot-1], v.wdl);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_remaining"}, 64'(remaining), 64'd0);
        chk({tag, "_haddr"}, 64'(HADDR), 64'd0);
        chk({tag, "_htrans"}, 64'(HTRANS), 64'd0);
        chk({tag, "_hwrite"}, {63'd0, HWRITE}, 64'd0);
        chk({tag, "_hwdata"}, HWDATA, 64'd0);
`ifdef AHBL_DMA_ABORT_EN
        chk({tag, "_aborted"}, {63'd0, aborted}, 64'd0);
`endif
    endtask

    vec_t tbl [NV];

    initial begin
        int found;
        for (int i = 0; i < 16; i++) mem[i] = DBASE + 64'(i + 1);

        //            src           dst           cnt w  smask   amask  done rd wr rd0           rdl           wa0           wd0        wal           wdl        rem ab
        tbl[0] = mk(32'h1000_0000, 32'h2000_0000, 2, 0, 32'h0,  32'h0,  9, 2, 2, 32'h1000_0000, 32'h1000_0008, 32'h2000_0000, DBASE+1,  32'h2000_0008, DBASE+2,  0, 0);
        tbl[1] = mk(32'h1000_0008, 32'h2000_0100, 1, 2, 32'h0,  32'h0, 13, 1, 1, 32'h1000_0008, 32'h1000_0008, 32'h2000_0100, DBASE+2,  32'h2000_0100, DBASE+2,  0, 0);
        tbl[2] = mk(32'h1000_0000, 32'h2000_0000, 0, 0, 32'h0,  32'h0,  1, 0, 0, 32'h0,         32'h0,         32'h0,         64'h0,    32'h0,         64'h0,    0, 0);
        tbl[3] = mk(32'hFFFF_FFF8, 32'h3000_0010, 2, 0, 32'h0,  32'h0,  9, 2, 2, 32'hFFFF_FFF8, 32'h0000_0000, 32'h3000_0010, DBASE+16, 32'h3000_0018, DBASE+1,  0, 0);
        tbl[4] = mk(32'h1000_0020, 32'h4000_0000, 3, 1, 32'h0,  32'h0, 25, 3, 3, 32'h1000_0020, 32'h1000_0030, 32'h4000_0000, DBASE+5,  32'h4000_0010, DBASE+7,  0, 0);
        tbl[5] = mk(32'h1000_0000, 32'h5000_0000, 1, 0, 32'h14, 32'h0,  5, 1, 1, 32'h1000_0000, 32'h1000_0000, 32'h5000_0000, DBASE+1,  32'h5000_0000, DBASE+1,  0, 0);
`ifdef AHBL_DMA_ABORT_EN
        tbl[6] = mk(32'h1000_0000, 32'h6000_0000, 4, 0, 32'h0,  32'h40, 9, 2, 2, 32'h1000_0000, 32'h1000_0008, 32'h6000_0000, DBASE+1,  32'h6000_0008, DBASE+2,  2, 1);
`endif

        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk_reset_outputs("reset");
        chk("reset_hsize", 64'(HSIZE), 64'd3);

        for (int i = 0; i < NV; i++) run_vec(tbl[i], $sformatf("v%0d", i));

        chk("stall_seen", {63'd0, (stall_seen != 0)}, 64'd1);
        chk("stall_stable", 64'(stall_viol), 64'd0);

        // Asynchronous reset during the write address phase.
        waits = 0;
        @(posedge HCLK); #1;
        src_addr = 32'h1000_0000; dst_addr = 32'h7000_0000; count = 16'd2; start = 1'b1;
        @(posedge HCLK); #1;
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge HCLK);
            if (HTRANS == 2'b10 && HWRITE) begin
                found = 1;
                break;
            end
        end
        chk("rst_reach_wr_a", 64'(found), 64'd1);
        #1 HRESETn = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge HCLK);
        HRESETn = 1'b1;
        run_vec(mk(32'h1000_0010, 32'h7000_0100, 1, 0, 32'h0, 32'h0, 5, 1, 1,
                   32'h1000_0010, 32'h1000_0010, 32'h7000_0100, DBASE+3,
                   32'h7000_0100, DBASE+3, 0, 0), "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
